mesh_nic: RTL
=============

# mesh_nic

Network interface that attaches one processing element (PE) to the local port of a mesh router tile in the 4x4 mesh. It packs PE requests into 64-bit packets and buffers them in an injection FIFO that drives the router's local input. It also accepts packets from the router's local output into an ejection FIFO and unpacks them for the PE. Each tile has one instance, parameterised with that tile's (X_ID, Y_ID).

## Interface
- PACKET_WIDTH, 64, packet width; fixed at 64 by the packet format.
- X_ID, 0, tile column, 0..3.
- Y_ID, 0, tile row, 0..3.
- FIFO_DEPTH, 4, entries per FIFO; must be a power of two, at least 2.

- clk  in  1  single clock; everything is on the rising edge.
- reset  in  1  synchronous, active-high.
- pe_req_valid  in  1  PE has a request.
- pe_req_ready  out  1  NIC can accept a request.
- pe_dest_x, pe_dest_y  in  2 each  destination tile.
- pe_payload  in  32  request payload.
- peso  out  1  send to the router local input.
- pedo  out  64  packet to the router.
- peri  in  1  router local input ready.
- pesi  in  1  router local output send.
- pedi  in  64  packet from the router.
- pero  out  1  NIC ready to accept from the router.
- pe_rsp_valid  out  1  ejected packet is available.
- pe_rsp_ready  in  1  PE consumes the packet.
- pe_rsp_src_x, pe_rsp_src_y  out  2 each  source tile of the packet.
- pe_rsp_seq  out  8  sequence number of the packet.
- pe_rsp_payload  out  32  payload of the packet.
- err_count  out  8  count of misdelivered packets; saturates at 255.

## Operation
- Packet format:
  - [63:62] dest_x, [61:60] dest_y.
  - [59:58] src_x, [57:56] src_y.
  - [55:48] seq.
  - [47:32] zero.
  - [31:0] payload.
- Handshakes: every channel transfers a packet on a cycle where its send/valid and ready are both high. A sender holds its data stable while send/valid is high.
- Injection path:
  - pe_req_ready = !inj_full. It does not depend on a same-cycle pop.
  - On a PE accept: push {pe_dest_x, pe_dest_y, X_ID, Y_ID, seq_ctr, 16'h0, pe_payload} into the injection FIFO, then seq_ctr <= seq_ctr + 1.
  - seq_ctr is 8 bits and wraps from 255 to 0.
- Injection to router:
  - peso = !inj_empty and pedo = the FIFO head, both driven from registers with no combinational path from PE inputs.
  - The FIFO pops on peso && peri.
- Ejection path:
  - pero = !ej_full.
  - On pesi && pero: if pedi[63:60] == {X_ID, Y_ID}, push pedi into the ejection FIFO.
  - Otherwise drop the packet and increment err_count, saturating at 255. A dropped packet is still handshaken (consumed).
- Ejection to PE:
  - pe_rsp_valid = !ej_empty.
  - The pe_rsp_* fields are sliced from the head entry.
  - The FIFO pops on pe_rsp_valid && pe_rsp_ready.
- FIFOs:
  - Circular buffers with read/write pointers of log2(FIFO_DEPTH) bits that wrap modulo the depth.
  - The count is log2(FIFO_DEPTH)+1 bits.
  - A simultaneous push and pop leaves the count unchanged and updates both pointers.
  - A push is never issued when full, because ready gates it. A pop is never issued when empty.
- A self-addressed request (dest equals own ID) is injected normally.

## Timing
- Reset, in the cycle reset is sampled high:
  - Pointers, counts, seq_ctr and err_count go to 0.
  - peso=0, pedo=0, pe_rsp_valid=0.
  - pe_req_ready=1 and pero=1 (both FIFOs empty).
- Reset asserted mid-transfer discards all buffered packets. In-flight handshakes in that cycle do not complete.
- Latency: a PE accept at edge N makes peso high in cycle N+1. A router accept at edge N makes pe_rsp_valid high in cycle N+1.
- Throughput: one packet per cycle per path when the downstream is always ready.
- Full FIFO + simultaneous pop: ready stays low that cycle. It rises the cycle after the pop.
- Empty FIFO + push: valid rises next cycle. There is no same-cycle bypass.
- err_count updates one cycle after the offending handshake.

## Test plan
- Reset then single inject, X_ID=1, Y_ID=2:
  - Stimulus: dest (3,0), payload 32'hDEADBEEF, peri=1.
  - Response: one cycle later, peso=1 and pedo=64'hC600_0000_DEADBEEF. It pops the next edge; seq becomes 1.
- Backpressure fill:
  - Stimulus: peri=0, push 5 requests back-to-back.
  - Response: 4 accepted, pe_req_ready=0 after the 4th. Then set peri=1: packets drain in order with seq 0,1,2,3; ready reasserts one cycle after the first pop.
- Ejection with stall:
  - Stimulus: pe_rsp_ready=0, router sends 4 valid packets to (1,2).
  - Response: pero drops after the 4th. A 5th send is not accepted until the PE pops. Fields read src, seq and payload correctly in order.
- Misdelivery:
  - Stimulus: a packet with dest (0,0) arrives at tile (1,2).
  - Response: it is consumed, not ejected, and err_count=1. After 300 such packets, err_count=255.
- Sequence wrap:
  - Stimulus: 257 injections.
  - Response: the seq field goes 255, 0, and packet 257 carries seq 0.
- Concurrent traffic plus mid-stream reset:
  - Stimulus: simultaneous push/pop on both FIFOs at depth 2 holds the count at 2. Then assert reset with both FIFOs non-empty.
  - Response: next cycle peso=0, pe_rsp_valid=0, both readies=1, err_count=0.

Source files
------------

// File: rtl/mesh_nic.sv
// Mesh network interface: packs PE requests into 64-bit packets for the router's
// local input and unpacks packets addressed to this tile for the PE.

module mesh_nic_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] rdata
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0]   FULL_CNT = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0]   CNT_ONE  = 1;
    localparam logic [PTR_W-1:0] PTR_ONE  = 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_push, do_pop;

    assign full    = (count_q == FULL_CNT);
    assign empty   = (count_q == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    // Stale storage is masked while empty, so outputs read zero after reset.
    assign rdata   = empty ? '0 : mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + PTR_ONE;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module mesh_nic #(
    parameter int PACKET_WIDTH = 64,
    parameter int X_ID         = 0,
    parameter int Y_ID         = 0,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    pe_req_valid,
    output logic                    pe_req_ready,
    input  logic [1:0]              pe_dest_x,
    input  logic [1:0]              pe_dest_y,
    input  logic [31:0]             pe_payload,
    output logic                    peso,
    output logic [PACKET_WIDTH-1:0] pedo,
    input  logic                    peri,
    input  logic                    pesi,
    input  logic [PACKET_WIDTH-1:0] pedi,
    output logic                    pero,
    output logic                    pe_rsp_valid,
    input  logic                    pe_rsp_ready,
    output logic [1:0]              pe_rsp_src_x,
    output logic [1:0]              pe_rsp_src_y,
    output logic [7:0]              pe_rsp_seq,
    output logic [31:0]             pe_rsp_payload,
    output logic [7:0]              err_count
);
    localparam logic [1:0] MY_X = 2'(X_ID);
    localparam logic [1:0] MY_Y = 2'(Y_ID);

    logic [7:0]              seq_ctr_q, seq_ctr_d;
    logic [7:0]              err_count_q, err_count_d;
    logic                    inj_full, inj_empty, inj_push, inj_pop;
    logic                    ej_full, ej_empty, ej_push, ej_pop, ej_accept, dest_match;
    logic [PACKET_WIDTH-1:0] inj_pkt, ej_head;
    logic                    ej_rsvd_unused;

    assign pe_req_ready = !inj_full;
    assign inj_push     = pe_req_valid && pe_req_ready;
    assign inj_pkt      = {pe_dest_x, pe_dest_y, MY_X, MY_Y, seq_ctr_q, 16'h0, pe_payload};
    assign peso         = !inj_empty;
    assign inj_pop      = peso && peri;

    mesh_nic_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_inj_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (inj_push),
        .wdata (inj_pkt),
        .pop   (inj_pop),
        .full  (inj_full),
        .empty (inj_empty),
        .rdata (pedo)
    );

    // Misaddressed packets are still handshaken so they cannot wedge the router.
    assign pero       = !ej_full;
    assign ej_accept  = pesi && pero;
    assign dest_match = (pedi[63:60] == {MY_X, MY_Y});
    assign ej_push    = ej_accept && dest_match;
    assign pe_rsp_valid = !ej_empty;
    assign ej_pop     = pe_rsp_valid && pe_rsp_ready;

    mesh_nic_fifo #(.WIDTH(PACKET_WIDTH), .DEPTH(FIFO_DEPTH)) u_ej_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (ej_push),
        .wdata (pedi),
        .pop   (ej_pop),
        .full  (ej_full),
        .empty (ej_empty),
        .rdata (ej_head)
    );

    assign pe_rsp_src_x   = ej_head[59:58];
    assign pe_rsp_src_y   = ej_head[57:56];
    assign pe_rsp_seq     = ej_head[55:48];
    assign pe_rsp_payload = ej_head[31:0];
    assign ej_rsvd_unused = ^{ej_head[63:60], ej_head[47:32]};
    assign err_count      = err_count_q;

    always_comb begin
        seq_ctr_d   = seq_ctr_q;
        err_count_d = err_count_q;
        if (inj_push) begin
            seq_ctr_d = seq_ctr_q + 8'd1;
        end
        if (ej_accept && !dest_match && (err_count_q != 8'hFF)) begin
            err_count_d = err_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            seq_ctr_q   <= '0;
            err_count_q <= '0;
        end else begin
            seq_ctr_q   <= seq_ctr_d;
            err_count_q <= err_count_d;
        end
    end
endmodule
